// File: rtl/inv_checker.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | inv_checker: drives an alternating 0/1 pattern into an external       |
// | inverter, checks the synchronized response once per step and reports  |
// | a saturating mismatch count plus a pass flag.                          |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module inv_checker #(
   parameter int HOLD_CYCLES = 10,
   parameter int NUM_STEPS   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       dut_in,
   input  logic       dut_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] err_count,
   output logic [7:0] step
);

   localparam logic [7:0] c_HOLD_LAST = 8'(HOLD_CYCLES - 2);
   localparam logic [7:0] c_STEP_LAST = 8'(NUM_STEPS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_CHECK = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] hold_q, hold_d;
   logic [7:0] step_q, step_d;
   logic [7:0] err_q, err_d;
   logic       pass_q, pass_d;
   logic       dut_in_q, dut_in_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       sync1_q, sync2_q;
   logic       mismatch;

   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      step_d   = step_q;
      err_d    = err_q;
      pass_d   = pass_q;
      // A healthy inverter output is the complement of what we drive.
      mismatch = (sync2_q == dut_in_q);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_DRIVE;
               hold_d  = 8'd0;
               step_d  = 8'd0;
               err_d   = 8'd0;
               pass_d  = 1'b0;
            end
         end
         S_DRIVE: begin
            if (hold_q == c_HOLD_LAST) begin
               state_d = S_CHECK;
            end else begin
               hold_d = hold_q + 8'd1;
            end
         end
         S_CHECK: begin
            if (mismatch && (err_q != 8'hFF)) begin
               err_d = err_q + 8'd1;
            end
            if (step_q == c_STEP_LAST) begin
               state_d = S_DONE;
               pass_d  = (err_d == 8'd0);
            end else begin
               state_d = S_DRIVE;
               step_d  = step_q + 8'd1;
               hold_d  = 8'd0;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they appear registered.
      busy_d   = (state_d == S_DRIVE) || (state_d == S_CHECK);
      done_d   = (state_d == S_DONE);
      dut_in_d = busy_d ? step_d[0] : 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         hold_q   <= 8'd0;
         step_q   <= 8'd0;
         err_q    <= 8'd0;
         pass_q   <= 1'b0;
         dut_in_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         step_q   <= step_d;
         err_q    <= err_d;
         pass_q   <= pass_d;
         dut_in_q <= dut_in_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         sync1_q  <= dut_out;
         sync2_q  <= sync1_q;
      end
   end

   assign dut_in    = dut_in_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_q;
   assign step      = step_q;

endmodule
`default_nettype wire

// File: tb/tb_inv_checker.sv
`timescale 1ns/1ps
`default_nettype none
// Self-checking bench for inv_checker: three instances (default, long run,
// minimal run) with behavioural inverter models and a step-level reference.
module tb_inv_checker;

   localparam int A_H  = 10;
   localparam int A_N  = 4;
   localparam int A_NH = A_H * A_N;
   localparam int B_N  = 255;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;

   logic       start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
   logic       dut_in_a, dut_in_b, dut_in_c;
   logic       dut_out_a, dut_out_b, dut_out_c;
   logic       busy_a, busy_b, busy_c;
   logic       done_a, done_b, done_c;
   logic       pass_a, pass_b, pass_c;
   logic [7:0] err_a, err_b, err_c;
   logic [7:0] step_a, step_b, step_c;
   logic [1:0] mode_a = 2'd0;   // 0 inverter, 1 stuck-0, 2 stuck-1, 3 buffer

   always #5 clk = ~clk;

   assign #1 dut_out_a = (mode_a == 2'd0) ? ~dut_in_a :
                         (mode_a == 2'd1) ? 1'b0 :
                         (mode_a == 2'd2) ? 1'b1 : dut_in_a;
   assign #1 dut_out_b = dut_in_b;
   assign #1 dut_out_c = ~dut_in_c;

   inv_checker u_dut_a (
      .clk(clk), .rst(rst), .start(start_a), .dut_in(dut_in_a), .dut_out(dut_out_a),
      .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a), .step(step_a));

   inv_checker #(.HOLD_CYCLES(10), .NUM_STEPS(B_N)) u_dut_b (
      .clk(clk), .rst(rst), .start(start_b), .dut_in(dut_in_b), .dut_out(dut_out_b),
      .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b), .step(step_b));

   inv_checker #(.HOLD_CYCLES(2), .NUM_STEPS(1)) u_dut_c (
      .clk(clk), .rst(rst), .start(start_c), .dut_in(dut_in_c), .dut_out(dut_out_c),
      .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c), .step(step_c));

   // Expected error count after n steps: step s drives s%2, a healthy
   // inverter answers the complement; the count saturates at 255.
   function automatic int model_errs(input int mode, input int n);
      int c = 0;
      for (int s = 0; s < n; s++) begin
         int v   = s % 2;
         int obs = (mode == 0) ? 1 - v : (mode == 1) ? 0 : (mode == 2) ? 1 : v;
         if (obs != 1 - v) c++;
      end
      return (c > 255) ? 255 : c;
   endfunction

   task automatic test_reset();
      logic [19:0] obs;
      @(negedge clk);
      rst = 1'b1; start_a = 1'b1; start_b = 1'b1; start_c = 1'b1;
      repeat (3) @(negedge clk);
      obs = {busy_a, done_a, dut_in_a, pass_a, err_a, step_a};
      total++; if (obs !== 20'd0) begin bad++; $display("FAIL reset_a: got %h want 0", obs); end
      obs = {busy_b, done_b, dut_in_b, pass_b, err_b, step_b};
      total++; if (obs !== 20'd0) begin bad++; $display("FAIL reset_b: got %h want 0", obs); end
      obs = {busy_c, done_c, dut_in_c, pass_c, err_c, step_c};
      total++; if (obs !== 20'd0) begin bad++; $display("FAIL reset_c: got %h want 0", obs); end
      rst = 1'b0; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   // One full run on instance A, checked cycle by cycle from the start edge.
   task automatic test_full_run(input int mode, input bit noise, input int gap, input string tag);
      int          exp_err;
      logic [11:0] obs, want;
      mode_a = 2'(mode);
      repeat (gap) @(negedge clk);
      exp_err = model_errs(mode, A_N);
      start_a = 1'b1;
      for (int k = 0; k <= A_NH + 2; k++) begin
         @(negedge clk);
         obs = {busy_a, done_a, dut_in_a, pass_a, step_a};
         if (k < A_NH)
            want = {1'b1, 1'b0, 1'((k / A_H) % 2), 1'b0, 8'(k / A_H)};
         else if (k == A_NH)
            want = {1'b0, 1'b1, 1'b0, 1'(exp_err == 0), 8'(A_N - 1)};
         else
            want = {1'b0, 1'b0, 1'b0, 1'(exp_err == 0), 8'(A_N - 1)};
         total++;
         if (obs !== want) begin
            bad++; $display("FAIL %s k=%0d {busy,done,in,pass,step}: got %h want %h", tag, k, obs, want);
         end
         if (k == 0) begin
            total++; if (err_a !== 8'd0) begin bad++; $display("FAIL %s err_clear: got %0d want 0", tag, err_a); end
         end
         if (k >= A_NH) begin
            total++;
            if (err_a !== 8'(exp_err)) begin
               bad++; $display("FAIL %s k=%0d err_count: got %0d want %0d", tag, k, err_a, exp_err);
            end
         end
         start_a = (noise && k < A_NH + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
   endtask

   task automatic test_start_held();
      logic [1:0] obs, want;
      bit         seen;
      mode_a = 2'd0;
      repeat (3) @(negedge clk);
      start_a = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         obs  = {busy_a, done_a};
         want = {1'(!(k == 40 || k == 41 || k == 82 || k == 83)), 1'(k == 40 || k == 82)};
         total++;
         if (obs !== want) begin bad++; $display("FAIL held k=%0d {busy,done}: got %b want %b", k, obs, want); end
      end
      start_a = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 200 && !seen; k++) begin
         @(negedge clk);
         if (done_a === 1'b1) seen = 1'b1;
      end
      total++; if (!seen) begin bad++; $display("FAIL held_drain: got no done want done"); end
      repeat (2) @(negedge clk);
      total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL held_idle busy: got %b want 0", busy_a); end
   endtask

   task automatic test_rst_midrun();
      logic [19:0] obs;
      mode_a = 2'd0;
      repeat (3) @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (25) @(negedge clk);
      total++; if (step_a !== 8'd2) begin bad++; $display("FAIL midrun step: got %0d want 2", step_a); end
      rst = 1'b1;
      @(negedge clk);
      obs = {busy_a, done_a, dut_in_a, pass_a, err_a, step_a};
      total++; if (obs !== 20'd0) begin bad++; $display("FAIL midrun_reset: got %h want 0", obs); end
      rst = 1'b0;
      test_full_run(0, 1'b0, 0, "after_rst");
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++) begin
         test_full_run(int'($urandom_range(0, 3)), 1'b1, int'($urandom_range(0, 5)), "random");
      end
   endtask

   task automatic test_buffer_255();
      int exp_mid = model_errs(3, 100);
      int exp_end = model_errs(3, B_N);
      start_b = 1'b1;
      for (int k = 0; k <= 10 * B_N + 1; k++) begin
         @(negedge clk);
         start_b = 1'b0;
         total++;
         if (done_b !== 1'(k == 10 * B_N)) begin
            bad++; $display("FAIL buf255 k=%0d done: got %b want %b", k, done_b, k == 10 * B_N);
         end
         if (k == 1000) begin
            total++; if (err_b !== 8'(exp_mid)) begin bad++; $display("FAIL buf255 mid err: got %0d want %0d", err_b, exp_mid); end
         end
         if (k == 10 * B_N) begin
            total++; if (err_b !== 8'(exp_end)) begin bad++; $display("FAIL buf255 err: got %0d want %0d", err_b, exp_end); end
            total++; if (pass_b !== 1'b0) begin bad++; $display("FAIL buf255 pass: got %b want 0", pass_b); end
            total++; if (step_b !== 8'd254) begin bad++; $display("FAIL buf255 step: got %0d want 254", step_b); end
            total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL buf255 busy: got %b want 0", busy_b); end
         end
      end
   endtask

   task automatic test_short();
      logic [11:0] obs, want;
      start_c = 1'b1;
      for (int k = 0; k <= 3; k++) begin
         @(negedge clk);
         start_c = 1'b0;
         obs  = {busy_c, done_c, pass_c, err_c, dut_in_c};
         want = (k < 2) ? {1'b1, 1'b0, 1'b0, 8'd0, 1'b0} :
                (k == 2) ? {1'b0, 1'b1, 1'b1, 8'd0, 1'b0} : {1'b0, 1'b0, 1'b1, 8'd0, 1'b0};
         total++;
         if (obs !== want) begin bad++; $display("FAIL short k=%0d {busy,done,pass,err,in}: got %h want %h", k, obs, want); end
      end
   endtask

   initial begin
      test_reset();
      test_full_run(0, 1'b0, 2, "good");
      test_full_run(1, 1'b0, 2, "stuck0");
      test_full_run(3, 1'b0, 2, "buffer");
      test_start_held();
      test_rst_midrun();
      test_random();
      test_buffer_255();
      test_short();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
